// File: rtl/pipelined_controller.sv
// Pipelined MIPS control unit: decodes in ID and carries the control word through
// the ID/EX, EX/MEM and MEM/WB registers, with stall, flush and multi-cycle multiply hold.
module pipelined_controller #(
  parameter int ALUOP_W     = 5,
  parameter int BJ_W        = 3,
  parameter int MUL_LATENCY = 4,
  parameter int CNT_W       = 3
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic [5:0]         Opcode,
  input  logic [5:0]         Funct,
  input  logic               IdValid,
  input  logic               Stall,
  input  logic               Flush,
  output logic               ExRegDst,
  output logic               ExALUSource,
  output logic               ExZeroExtend,
  output logic               ExMulOp,
  output logic               ExJalBit,
  output logic [ALUOP_W-1:0] ExALUOp,
  output logic [BJ_W-1:0]    ExBranchJump,
  output logic               MemRead,
  output logic               MemWrite,
  output logic [1:0]         MemDataType,
  output logic               WbRegWrite,
  output logic               WbMemToReg,
  output logic               WbJalBit,
  output logic               MulBusy,
  output logic               IdStall
);

  typedef struct packed {
    logic               reg_dst;
    logic               alu_src;
    logic               mem_to_reg;
    logic               reg_write;
    logic               mem_read;
    logic               mem_write;
    logic [BJ_W-1:0]    bj;
    logic [ALUOP_W-1:0] alu_op;
    logic               mul_op;
    logic               zero_ext;
    logic [1:0]         dtype;
    logic               jal;
  } ctrl_t;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic [1:0] dtype;
    logic       reg_write;
    logic       mem_to_reg;
    logic       jal;
  } mem_ctrl_t;

  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
    logic jal;
  } wb_ctrl_t;

  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_LATENCY - 1);

  // ALU-immediate group shares everything except ALUOp and the sign/zero extension choice.
  function automatic ctrl_t imm_alu(input logic [4:0] op5, input logic ze);
    ctrl_t c;
    c            = '0;
    c.reg_dst    = 1'b1;
    c.alu_src    = 1'b1;
    c.mem_to_reg = 1'b1;
    c.reg_write  = 1'b1;
    c.alu_op     = ALUOP_W'(op5);
    c.zero_ext   = ze;
    return c;
  endfunction

  function automatic ctrl_t load_op(input logic [1:0] dt, input logic rd);
    ctrl_t c;
    c           = '0;
    c.reg_dst   = rd;
    c.alu_src   = 1'b1;
    c.reg_write = 1'b1;
    c.mem_read  = 1'b1;
    c.alu_op    = ALUOP_W'(5'b00010);
    c.dtype     = dt;
    return c;
  endfunction

  function automatic ctrl_t store_op(input logic [1:0] dt);
    ctrl_t c;
    c           = '0;
    c.alu_src   = 1'b1;
    c.mem_write = 1'b1;
    c.alu_op    = ALUOP_W'(5'b00010);
    c.dtype     = dt;
    return c;
  endfunction

  function automatic ctrl_t branch_op(input logic [2:0] bj3, input logic [4:0] op5);
    ctrl_t c;
    c        = '0;
    c.bj     = BJ_W'(bj3);
    c.alu_op = ALUOP_W'(op5);
    return c;
  endfunction

  function automatic ctrl_t decode(input logic [5:0] op, input logic [5:0] fn, input logic vld);
    ctrl_t c;
    c = '0;
    if (vld) begin
      case (op)
        6'b000000: begin
          c.mem_to_reg = 1'b1;
          c.reg_write  = 1'b1;
          c.mul_op     = (fn == 6'b011000) || (fn == 6'b011001);
        end
        6'b011100: begin
          c.mem_to_reg = 1'b1;
          c.reg_write  = 1'b1;
          c.alu_op     = ALUOP_W'(5'b01000);
          c.mul_op     = 1'b1;
        end
        6'b011111: begin
          c.mem_to_reg = 1'b1;
          c.reg_write  = 1'b1;
          c.alu_op     = ALUOP_W'(5'b01001);
        end
        6'b001000: c = imm_alu(5'b00010, 1'b0);
        6'b001001: c = imm_alu(5'b00111, 1'b1);
        6'b001100: c = imm_alu(5'b00001, 1'b1);
        6'b001101: c = imm_alu(5'b00011, 1'b1);
        6'b001110: c = imm_alu(5'b00100, 1'b1);
        6'b001010: c = imm_alu(5'b00101, 1'b0);
        6'b001011: c = imm_alu(5'b01011, 1'b1);
        6'b100011: c = load_op(2'b10, 1'b1);
        6'b100001: c = load_op(2'b01, 1'b0);
        6'b100000: c = load_op(2'b00, 1'b0);
        6'b101011: c = store_op(2'b10);
        6'b101001: c = store_op(2'b01);
        6'b101000: c = store_op(2'b00);
        6'b001111: begin
          c.reg_write = 1'b1;
          c.mem_read  = 1'b1;
          c.alu_op    = ALUOP_W'(5'b00010);
        end
        6'b000100: c = branch_op(3'b001, 5'b00001);
        6'b000101: c = branch_op(3'b010, 5'b00001);
        6'b000001: c = branch_op(3'b100, 5'b00000);
        6'b000111: c = branch_op(3'b101, 5'b00000);
        6'b000110: c = branch_op(3'b110, 5'b00000);
        6'b000010: c = branch_op(3'b011, 5'b00000);
        6'b000011: begin
          c           = branch_op(3'b011, 5'b10000);
          c.reg_write = 1'b1;
          c.jal       = 1'b1;
        end
        default: c = '0;
      endcase
    end else begin
      c = '0;
    end
    return c;
  endfunction

  logic             idex_valid_q, idex_valid_d;
  ctrl_t            idex_ctrl_q, idex_ctrl_d;
  logic             exmem_valid_q, exmem_valid_d;
  mem_ctrl_t        exmem_ctrl_q, exmem_ctrl_d;
  logic             memwb_valid_q, memwb_valid_d;
  wb_ctrl_t         memwb_ctrl_q, memwb_ctrl_d;
  logic [CNT_W-1:0] mul_cnt_q, mul_cnt_d;
  logic             mul_busy_s;
  ctrl_t            id_ctrl_s;

  assign id_ctrl_s  = decode(Opcode, Funct, IdValid);
  assign mul_busy_s = idex_valid_q & idex_ctrl_q.mul_op & (mul_cnt_q != MUL_LAST);

  // ID/EX next state: a running multiply holds the slot and outranks flush and stall.
  always_comb begin
    idex_valid_d = idex_valid_q;
    idex_ctrl_d  = idex_ctrl_q;
    if (mul_busy_s) begin
      idex_valid_d = idex_valid_q;
      idex_ctrl_d  = idex_ctrl_q;
    end else if (Flush || Stall) begin
      idex_valid_d = 1'b0;
      idex_ctrl_d  = '0;
    end else begin
      idex_valid_d = IdValid;
      idex_ctrl_d  = id_ctrl_s;
    end
  end

  // Downstream stages always advance; they take a bubble behind a stalled EX.
  always_comb begin
    exmem_valid_d = 1'b0;
    exmem_ctrl_d  = '0;
    memwb_valid_d = 1'b0;
    memwb_ctrl_d  = '0;
    mul_cnt_d     = {CNT_W{1'b0}};
    if (idex_valid_q && !mul_busy_s) begin
      exmem_valid_d           = 1'b1;
      exmem_ctrl_d.mem_read   = idex_ctrl_q.mem_read;
      exmem_ctrl_d.mem_write  = idex_ctrl_q.mem_write;
      exmem_ctrl_d.dtype      = idex_ctrl_q.dtype;
      exmem_ctrl_d.reg_write  = idex_ctrl_q.reg_write;
      exmem_ctrl_d.mem_to_reg = idex_ctrl_q.mem_to_reg;
      exmem_ctrl_d.jal        = idex_ctrl_q.jal;
    end else begin
      exmem_valid_d = 1'b0;
      exmem_ctrl_d  = '0;
    end
    if (exmem_valid_q) begin
      memwb_valid_d           = 1'b1;
      memwb_ctrl_d.reg_write  = exmem_ctrl_q.reg_write;
      memwb_ctrl_d.mem_to_reg = exmem_ctrl_q.mem_to_reg;
      memwb_ctrl_d.jal        = exmem_ctrl_q.jal;
    end else begin
      memwb_valid_d = 1'b0;
      memwb_ctrl_d  = '0;
    end
    if (mul_busy_s) begin
      mul_cnt_d = mul_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      mul_cnt_d = {CNT_W{1'b0}};
    end
  end

  // Stage registers and multiply counter.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      idex_valid_q  <= 1'b0;
      idex_ctrl_q   <= '0;
      exmem_valid_q <= 1'b0;
      exmem_ctrl_q  <= '0;
      memwb_valid_q <= 1'b0;
      memwb_ctrl_q  <= '0;
      mul_cnt_q     <= {CNT_W{1'b0}};
    end else begin
      idex_valid_q  <= idex_valid_d;
      idex_ctrl_q   <= idex_ctrl_d;
      exmem_valid_q <= exmem_valid_d;
      exmem_ctrl_q  <= exmem_ctrl_d;
      memwb_valid_q <= memwb_valid_d;
      memwb_ctrl_q  <= memwb_ctrl_d;
      mul_cnt_q     <= mul_cnt_d;
    end
  end

  // An invalid stage presents all-zero control to the datapath.
  assign ExRegDst     = idex_valid_q & idex_ctrl_q.reg_dst;
  assign ExALUSource  = idex_valid_q & idex_ctrl_q.alu_src;
  assign ExZeroExtend = idex_valid_q & idex_ctrl_q.zero_ext;
  assign ExMulOp      = idex_valid_q & idex_ctrl_q.mul_op;
  assign ExJalBit     = idex_valid_q & idex_ctrl_q.jal;
  assign ExALUOp      = idex_valid_q ? idex_ctrl_q.alu_op : {ALUOP_W{1'b0}};
  assign ExBranchJump = idex_valid_q ? idex_ctrl_q.bj : {BJ_W{1'b0}};
  assign MemRead      = exmem_valid_q & exmem_ctrl_q.mem_read;
  assign MemWrite     = exmem_valid_q & exmem_ctrl_q.mem_write;
  assign MemDataType  = exmem_valid_q ? exmem_ctrl_q.dtype : 2'b00;
  assign WbRegWrite   = memwb_valid_q & memwb_ctrl_q.reg_write;
  assign WbMemToReg   = memwb_valid_q & memwb_ctrl_q.mem_to_reg;
  assign WbJalBit     = memwb_valid_q & memwb_ctrl_q.jal;
  assign MulBusy      = mul_busy_s;
  assign IdStall      = mul_busy_s | Stall;

endmodule

// File: tb/tb_pipelined_controller.sv
// Bench for pipelined_controller: decode table, directed hazard/multiply/reset
// sequences and random traffic, all checked against a slot-level pipeline model.
module tb_pipelined_controller;
  localparam int L = 4;

  logic       Clk = 1'b0;
  logic       Reset_n, IdValid, Stall, Flush;
  logic [5:0] Opcode, Funct;
  logic       ExRegDst, ExALUSource, ExZeroExtend, ExMulOp, ExJalBit;
  logic [4:0] ExALUOp;
  logic [2:0] ExBranchJump;
  logic       MemRead, MemWrite;
  logic [1:0] MemDataType;
  logic       WbRegWrite, WbMemToReg, WbJalBit, MulBusy, IdStall;

  pipelined_controller #(.ALUOP_W(5), .BJ_W(3), .MUL_LATENCY(L), .CNT_W(3)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Opcode(Opcode), .Funct(Funct), .IdValid(IdValid),
    .Stall(Stall), .Flush(Flush), .ExRegDst(ExRegDst), .ExALUSource(ExALUSource),
    .ExZeroExtend(ExZeroExtend), .ExMulOp(ExMulOp), .ExJalBit(ExJalBit), .ExALUOp(ExALUOp),
    .ExBranchJump(ExBranchJump), .MemRead(MemRead), .MemWrite(MemWrite),
    .MemDataType(MemDataType), .WbRegWrite(WbRegWrite), .WbMemToReg(WbMemToReg),
    .WbJalBit(WbJalBit), .MulBusy(MulBusy), .IdStall(IdStall));

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic rd, as, mtr, rw, mr, mw;
    logic [2:0] bj;
    logic [4:0] alu;
    logic mul, ze;
    logic [1:0] dt;
    logic jal;
  } ctl_t;

  typedef struct {
    string      name;
    logic [5:0] op;
    logic [5:0] fn;
    ctl_t       exp;
  } vec_t;

  vec_t tbl[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  ctl_t m_ex, m_mem, m_wb;
  bit   m_ex_v;
  int   m_rem;

  function automatic ctl_t mk(logic rd, logic as, logic mtr, logic rw, logic mr, logic mw,
                              logic [2:0] bj, logic [4:0] alu, logic mul, logic ze,
                              logic [1:0] dt, logic jal);
    ctl_t c;
    c = '{rd, as, mtr, rw, mr, mw, bj, alu, mul, ze, dt, jal};
    return c;
  endfunction

  task automatic add(input string nm, input logic [5:0] op, input logic [5:0] fn, input ctl_t e);
    vec_t v;
    v.name = nm; v.op = op; v.fn = fn; v.exp = e;
    tbl.push_back(v);
  endtask

  // Reference decode: R-type by its funct rule, everything else looked up in the table.
  function automatic ctl_t ref_decode(input logic [5:0] op, input logic [5:0] fn, input logic vld);
    if (!vld) return '0;
    if (op == 6'd0)
      return mk(0, 0, 1, 1, 0, 0, 3'd0, 5'd0, (fn == 6'b011000) || (fn == 6'b011001), 0, 2'd0, 0);
    foreach (tbl[i]) if (tbl[i].op == op) return tbl[i].exp;
    return '0;
  endfunction

  // One slot per stage; an instruction occupies EX for m_rem more edges.
  function automatic void model_edge();
    ctl_t nwb, nmem;
    nwb  = m_mem;
    nmem = (m_ex_v && m_rem == 1) ? m_ex : '0;
    if (m_ex_v && m_rem > 1) begin
      m_rem = m_rem - 1;
    end else if (Flush || Stall || !IdValid) begin
      m_ex_v = 0; m_ex = '0; m_rem = 0;
    end else begin
      m_ex_v = 1; m_ex = ref_decode(Opcode, Funct, 1'b1); m_rem = m_ex.mul ? L : 1;
    end
    m_mem = nmem;
    m_wb  = nwb;
  endfunction

  function automatic void model_reset();
    m_ex = '0; m_mem = '0; m_wb = '0; m_ex_v = 0; m_rem = 0;
  endfunction

  function automatic logic [21:0] exp_obs();
    logic busy;
    busy = m_ex_v && (m_rem > 1);
    return {m_ex.rd, m_ex.as, m_ex.ze, m_ex.mul, m_ex.jal, m_ex.alu, m_ex.bj,
            m_mem.mr, m_mem.mw, m_mem.dt, m_wb.rw, m_wb.mtr, m_wb.jal, busy, busy | Stall};
  endfunction

  function automatic logic [21:0] act_obs();
    return {ExRegDst, ExALUSource, ExZeroExtend, ExMulOp, ExJalBit, ExALUOp, ExBranchJump,
            MemRead, MemWrite, MemDataType, WbRegWrite, WbMemToReg, WbJalBit, MulBusy, IdStall};
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic v,
                       input logic st, input logic fl);
    Opcode = op; Funct = fn; IdValid = v; Stall = st; Flush = fl;
  endtask

  task automatic step(input string nm);
    @(posedge Clk);
    model_edge();
    #1;
    check(nm, {10'd0, act_obs()}, {10'd0, exp_obs()});
  endtask

  task automatic idle(input int n);
    drive(6'd0, 6'd0, 1'b0, 1'b0, 1'b0);
    repeat (n) step("drain");
  endtask

  logic [5:0] rop, rfn;
  int         ridx;

  initial begin
    add("add",   6'b000000, 6'b100000, mk(0,0,1,1,0,0,3'b000,5'b00000,0,0,2'b00,0));
    add("mult",  6'b000000, 6'b011000, mk(0,0,1,1,0,0,3'b000,5'b00000,1,0,2'b00,0));
    add("multu", 6'b000000, 6'b011001, mk(0,0,1,1,0,0,3'b000,5'b00000,1,0,2'b00,0));
    add("madd",  6'b011100, 6'b000000, mk(0,0,1,1,0,0,3'b000,5'b01000,1,0,2'b00,0));
    add("seb",   6'b011111, 6'b100000, mk(0,0,1,1,0,0,3'b000,5'b01001,0,0,2'b00,0));
    add("addi",  6'b001000, 6'b000000, mk(1,1,1,1,0,0,3'b000,5'b00010,0,0,2'b00,0));
    add("addiu", 6'b001001, 6'b000000, mk(1,1,1,1,0,0,3'b000,5'b00111,0,1,2'b00,0));
    add("andi",  6'b001100, 6'b000000, mk(1,1,1,1,0,0,3'b000,5'b00001,0,1,2'b00,0));
    add("ori",   6'b001101, 6'b000000, mk(1,1,1,1,0,0,3'b000,5'b00011,0,1,2'b00,0));
    add("xori",  6'b001110, 6'b000000, mk(1,1,1,1,0,0,3'b000,5'b00100,0,1,2'b00,0));
    add("slti",  6'b001010, 6'b000000, mk(1,1,1,1,0,0,3'b000,5'b00101,0,0,2'b00,0));
    add("sltiu", 6'b001011, 6'b000000, mk(1,1,1,1,0,0,3'b000,5'b01011,0,1,2'b00,0));
    add("lw",    6'b100011, 6'b000000, mk(1,1,0,1,1,0,3'b000,5'b00010,0,0,2'b10,0));
    add("lh",    6'b100001, 6'b000000, mk(0,1,0,1,1,0,3'b000,5'b00010,0,0,2'b01,0));
    add("lb",    6'b100000, 6'b000000, mk(0,1,0,1,1,0,3'b000,5'b00010,0,0,2'b00,0));
    add("sw",    6'b101011, 6'b000000, mk(0,1,0,0,0,1,3'b000,5'b00010,0,0,2'b10,0));
    add("sh",    6'b101001, 6'b000000, mk(0,1,0,0,0,1,3'b000,5'b00010,0,0,2'b01,0));
    add("sb",    6'b101000, 6'b000000, mk(0,1,0,0,0,1,3'b000,5'b00010,0,0,2'b00,0));
    add("lui",   6'b001111, 6'b000000, mk(0,0,0,1,1,0,3'b000,5'b00010,0,0,2'b00,0));
    add("beq",   6'b000100, 6'b000000, mk(0,0,0,0,0,0,3'b001,5'b00001,0,0,2'b00,0));
    add("bne",   6'b000101, 6'b000000, mk(0,0,0,0,0,0,3'b010,5'b00001,0,0,2'b00,0));
    add("regimm",6'b000001, 6'b000000, mk(0,0,0,0,0,0,3'b100,5'b00000,0,0,2'b00,0));
    add("bgtz",  6'b000111, 6'b000000, mk(0,0,0,0,0,0,3'b101,5'b00000,0,0,2'b00,0));
    add("blez",  6'b000110, 6'b000000, mk(0,0,0,0,0,0,3'b110,5'b00000,0,0,2'b00,0));
    add("j",     6'b000010, 6'b000000, mk(0,0,0,0,0,0,3'b011,5'b00000,0,0,2'b00,0));
    add("jal",   6'b000011, 6'b000000, mk(0,0,0,1,0,0,3'b011,5'b10000,0,0,2'b00,1));
    add("bad3f", 6'b111111, 6'b011000, mk(0,0,0,0,0,0,3'b000,5'b00000,0,0,2'b00,0));
    add("bad10", 6'b010000, 6'b000000, mk(0,0,0,0,0,0,3'b000,5'b00000,0,0,2'b00,0));

    Reset_n = 1'b0;
    drive(6'd0, 6'd0, 1'b0, 1'b0, 1'b0);
    model_reset();
    #12;
    check("reset_state", {10'd0, act_obs()}, 32'd0);
    Reset_n = 1'b1;

    // Decode table: each opcode alone, Ex fields compared straight against the table.
    foreach (tbl[i]) begin
      drive(tbl[i].op, tbl[i].fn, 1'b1, 1'b0, 1'b0);
      step({"issue_", tbl[i].name});
      check({"decode_", tbl[i].name},
            {18'd0, ExRegDst, ExALUSource, ExZeroExtend, ExMulOp, ExJalBit, ExALUOp, ExBranchJump},
            {18'd0, tbl[i].exp.rd, tbl[i].exp.as, tbl[i].exp.ze, tbl[i].exp.mul,
             tbl[i].exp.jal, tbl[i].exp.alu, tbl[i].exp.bj});
      idle(L + 2);
    end

    // Multiply followed by lw held in ID.
    drive(6'b000000, 6'b011000, 1'b1, 1'b0, 1'b0);
    step("mul_issue");
    drive(6'b100011, 6'b000000, 1'b1, 1'b0, 1'b0);
    for (int c = 0; c < L - 1; c++) begin
      check("mul_busy", {31'd0, MulBusy & IdStall & ExMulOp}, 32'd1);
      check("mul_mem_bubble", {30'd0, MemRead, MemWrite}, 32'd0);
      step("mul_hold");
    end
    check("mul_done", {30'd0, MulBusy, ExMulOp}, 32'd1);
    step("lw_enter");
    check("lw_in_ex", {31'd0, ExRegDst}, 32'd1);
    idle(1);
    check("lw_dtype", {30'd0, MemDataType}, 32'd2);
    idle(3);

    // Load-use stall with sw waiting in ID.
    drive(6'b100011, 6'd0, 1'b1, 1'b0, 1'b0);
    step("lw_issue");
    drive(6'b101011, 6'd0, 1'b1, 1'b1, 1'b0);
    step("stall_bubble");
    check("stall_ex_zero", {20'd0, ExRegDst, ExALUSource, ExALUOp, ExBranchJump, ExMulOp}, 32'd0);
    drive(6'b101011, 6'd0, 1'b1, 1'b0, 1'b0);
    step("sw_enter");
    check("sw_alusrc", {31'd0, ExALUSource}, 32'd1);
    idle(3);

    // Flush with stall on beq, then flush ignored while a multiply holds EX.
    drive(6'b000100, 6'd0, 1'b1, 1'b1, 1'b1);
    step("flush_stall");
    check("flush_bj", {29'd0, ExBranchJump}, 32'd0);
    drive(6'b011100, 6'd0, 1'b1, 1'b0, 1'b0);
    step("madd_issue");
    drive(6'b001000, 6'd0, 1'b1, 1'b0, 1'b1);
    step("flush_in_mul");
    check("flush_hold", {31'd0, ExMulOp}, 32'd1);
    idle(L + 2);

    // Asynchronous reset during the second cycle of a multiply.
    drive(6'b000000, 6'b011001, 1'b1, 1'b0, 1'b0);
    step("mul2_issue");
    drive(6'd0, 6'd0, 1'b0, 1'b0, 1'b0);
    step("mul2_cycle2");
    #2 Reset_n = 1'b0;
    #1;
    model_reset();
    check("async_reset", {10'd0, act_obs()}, 32'd0);
    @(negedge Clk);
    Reset_n = 1'b1;
    drive(6'b001000, 6'd0, 1'b1, 1'b0, 1'b0);
    step("addi_after_reset");
    check("addi_alu", {27'd0, ExALUOp}, 32'd2);
    idle(3);

    // Unknown opcode right after lw leaves no stale fields.
    drive(6'b100011, 6'd0, 1'b1, 1'b0, 1'b0);
    step("lw_before_bad");
    drive(6'b111111, 6'b011000, 1'b1, 1'b0, 1'b0);
    step("bad_opcode");
    idle(3);

    // Random traffic against the model.
    for (int c = 0; c < 600; c++) begin
      ridx = $urandom_range(0, tbl.size() + 3);
      if (ridx < tbl.size()) begin
        rop = tbl[ridx].op;
        rfn = (rop == 6'd0) ? (($urandom_range(0, 2) == 0) ? 6'(ridx[5:0] ^ 6'h18) : tbl[ridx].fn)
                            : 6'($urandom);
      end else begin
        rop = 6'($urandom);
        rfn = 6'($urandom);
      end
      drive(rop, rfn, ($urandom_range(0, 9) < 8) ? 1'b1 : 1'b0,
            ($urandom_range(0, 99) < 15) ? 1'b1 : 1'b0,
            ($urandom_range(0, 99) < 10) ? 1'b1 : 1'b0);
      step("random");
    end
    idle(L + 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
